// File: rtl/conv1_k_mem_write.sv
// Write-side counter/addresser for the conv1 kernel weight memory.
// Streams kernel A/B weight pairs into two write ports (0..HALF-1 and HALF..2*HALF-1).
module conv1_k_mem_write #(
    parameter int DATA_W = 8,
    parameter int HALF   = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_w0,
    input  logic [DATA_W-1:0] in_w1,
    output logic              in_ready,
    output logic              we0,
    output logic              we1,
    output logic [5:0]        addr0,
    output logic [5:0]        addr1,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [4:0]        count,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [5:0] PORT1_BASE = 6'(HALF);
    localparam logic [4:0] LAST_BEAT  = 5'(HALF - 1);

    state_t state;
    state_t state_next;
    logic   accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start is only honoured outside LOAD, so a stray pulse cannot restart a fill
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = enable;
                accept   = in_valid & enable;
                if (accept && (count == LAST_BEAT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we0      <= 1'b0;
            we1      <= 1'b0;
            addr0    <= 6'd0;
            addr1    <= PORT1_BASE;
            data0    <= '0;
            data1    <= '0;
            count    <= 5'd0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            we0  <= accept;
            we1  <= accept;
            done <= (state_next == DONE);
            if (accept) begin
                data0 <= in_w0;
                data1 <= in_w1;
                addr0 <= {1'b0, count};
                addr1 <= {1'b0, count} + PORT1_BASE;
                count <= count + 5'd1;
            end else if (start && (state != LOAD)) begin
                count <= 5'd0;
            end
            // a restart clears the flag even if a beat is offered in the same cycle
            if (state == DONE) begin
                if (start) begin
                    overflow <= 1'b0;
                end else if (in_valid) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
